imem_responder: RTL
===================

Name: imem_responder

Overview:
- Instruction-memory responder: the serving end of the fetch stage's instruction request interface.
- Accepts word-address fetch requests through a valid/ready handshake.
- Reads a local instruction array and returns each 32-bit instruction after a fixed pipeline latency, through a credit-limited response queue.
- Sits between the fetch stage and the instruction store; a side load port preloads the program.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words in the array (power of two).
- LATENCY, 2, cycles from request acceptance to earliest resp_valid (1..4).
- QUEUE_DEPTH, 4, maximum outstanding requests (in flight plus queued), power of two, >= LATENCY.
- NOP_WORD, 32'h00000013, instruction returned on an error response.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address of the requested instruction.
- resp_valid  out  1  response available.
- resp_ready  in  1  fetch stage consumes the response.
- resp_instruction  out  32  returned instruction word.
- resp_error  out  1  misaligned or out-of-range request.
- flush  in  1  discard all outstanding and queued responses.
- load_enable  in  1  write one array word.
- load_addr  in  $clog2(DEPTH)  word index for the load.
- load_data  in  32  word to store.

Behaviour:
- Reset (reset==0, asynchronous):
  - req_ready=0, resp_valid=0, resp_instruction=0, resp_error=0.
  - Pipeline valid bits, queue pointers and the outstanding counter cleared.
  - Array contents are not cleared.
  - req_ready rises on the first clock edge after reset deasserts.
- Accept:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready = !flush && (outstanding_q < QUEUE_DEPTH), where outstanding_q is registered. A pop in the same cycle does not raise req_ready until the next cycle.
- Address decode:
  - word index = req_addr[$clog2(DEPTH)+1:2].
  - Error if req_addr[1:0]!=0 or req_addr >= 4*DEPTH.
  - An error response carries resp_error=1 and resp_instruction=NOP_WORD; it occupies a slot like a normal response.
- Latency:
  - The array is read at the accept edge, then passes through LATENCY-1 valid-tagged pipeline registers into the queue.
  - With the queue empty, an accept in cycle N shows resp_valid=1 in cycle N+LATENCY.
  - Back-to-back accepts give one response per cycle.
- Response handshake:
  - The queue head drives resp_*. A pop occurs on resp_valid && resp_ready.
  - resp_* stays stable while resp_valid && !resp_ready.
  - Responses are returned strictly in request order.
- Counter:
  - outstanding increments on accept and decrements on pop; both in one cycle leaves it unchanged.
  - It can never exceed QUEUE_DEPTH, so the queue never overflows and pipeline stages never stall.
- Flush:
  - On the edge where flush==1: all pipeline valid bits, queue and outstanding are cleared, and resp_valid=0 the next cycle.
  - A request presented in the flush cycle is not accepted (req_ready=0).
  - A pop in the flush cycle is still counted as consumed by the fetch stage.
- Load port:
  - Writes the array on the edge.
  - A same-cycle accept to the same word reads the old data; the following cycle reads the new data.
  - load_addr is in-range by construction; no error path.
- Reset mid-operation drops all in-flight and queued responses; nothing is returned after reset.

Decomposition:
- Shared package vi_pkg: INSTR_WIDTH=32, NOP_WORD constant, and a response struct {instruction[31:0], error}.
- Sub-module resp_queue: synchronous FIFO with QUEUE_DEPTH entries and a flush/clear input. The responder instantiates one.

Test Plan:
- Load words 0..3 = 0xA0,0xA1,0xA2,0xA3. Issue req_addr 0x0,0x4,0x8,0xC back-to-back with resp_ready=1 -> resp_valid at cycles N+2..N+5, instructions 0xA0..0xA3, resp_error=0.
- Hold resp_ready=0 and issue 6 requests -> exactly 4 accepted, req_ready=0 afterwards. Responses stay stable. Then release resp_ready -> 4 responses in order, and req_ready=1 one cycle after the first pop.
- req_addr=0x6, then req_addr=4*DEPTH -> both resp_error=1 with resp_instruction=0x00000013. A following valid request returns normally.
- Two requests in flight, then assert flush for one cycle -> no resp_valid for those requests, outstanding=0. A next request to 0x8 returns 0xA2 at +2 cycles.
- load_enable to word 1 with 0xBEEF in the same cycle as accepting 0x4 -> that response is 0xA1; the next request to 0x4 returns 0xBEEF.
- Assert reset (drive 0) asynchronously mid-stream -> req_ready, resp_valid, resp_instruction and resp_error are 0 immediately. After release, the first request returns the correct array data with no stale responses.

Source files
------------

// File: rtl/vi_pkg.sv
// Shared types and constants for the instruction-memory responder.
package vi_pkg;
  localparam int INSTR_WIDTH = 32;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   error;
  } resp_t;
endpackage

// File: rtl/imem_responder_resp_queue.sv
// Synchronous response FIFO with a clear input; overflow is prevented upstream by
// the responder's outstanding-request credit.
module resp_queue
  import vi_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  clear,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output resp_t head,
  output logic  not_empty
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  resp_t         slots [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          pop_ok;

  assign not_empty = (count != '0);
  assign pop_ok    = pop && not_empty;
  assign head      = slots[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch requests, reads the local array and
// returns instructions in order after a fixed latency through a credit-limited queue.
module imem_responder
  import vi_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          LATENCY     = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] NOP_WORD    = vi_pkg::NOP_WORD
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_instruction,
  output logic                     resp_error,
  input  logic                     flush,
  input  logic                     load_enable,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int NSTG = LATENCY - 1;
  localparam logic [CW-1:0] QD_CNT     = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   ready_en;
  logic [CW-1:0]          outstanding_q;
  logic [AW-1:0]          word_idx;
  logic                   addr_err;
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   head_vld;
  resp_t                  rd_resp;
  resp_t                  push_data;
  resp_t                  head;

  // ready_en keeps req_ready low until the first edge after reset release
  assign req_ready = ready_en && !flush && (outstanding_q < QD_CNT);
  assign accept    = req_valid && req_ready;
  assign pop       = head_vld && resp_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign addr_err  = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);

  always_ff @(posedge clock) begin
    if (load_enable) mem[load_addr] <= load_data;
  end

  always_comb begin
    rd_resp.instruction = addr_err ? NOP_WORD : mem[word_idx];
    rd_resp.error       = addr_err;
  end

  generate
    if (NSTG == 0) begin : g_direct
      assign push      = accept;
      assign push_data = rd_resp;
    end else begin : g_pipe
      resp_t            data_p [NSTG];
      logic [NSTG-1:0]  vld_p;

      // stage p0 captures the array read at the accept edge
      always_ff @(posedge clock) begin
        data_p[0] <= rd_resp;
        for (int i = 1; i < NSTG; i++) data_p[i] <= data_p[i-1];
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          vld_p <= '0;
        end else if (flush) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= accept;
          for (int i = 1; i < NSTG; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      assign push      = vld_p[NSTG-1];
      assign push_data = data_p[NSTG-1];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en      <= 1'b0;
      outstanding_q <= '0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        outstanding_q <= '0;
      end else begin
        case ({accept, pop})
          2'b10:   outstanding_q <= outstanding_q + CNT_ONE;
          2'b01:   outstanding_q <= outstanding_q - CNT_ONE;
          default: outstanding_q <= outstanding_q;
        endcase
      end
    end
  end

  resp_queue #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .not_empty(head_vld)
  );

  // outputs read as zero whenever no response is presented, including during reset
  assign resp_valid       = head_vld;
  assign resp_instruction = head_vld ? head.instruction : '0;
  assign resp_error       = head_vld && head.error;
endmodule
